// File: rtl/axil_uart_regs_if.sv
// AXI4-Lite channel bundle for the UART register front-end.
// The master modport drives requests; the slave modport drives ready/response signals.
interface axil_uart_regs_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_awaddr;
    logic                    s_awvalid;
    logic                    s_awready;
    logic [DATA_WIDTH-1:0]   s_wdata;
    logic [DATA_WIDTH/8-1:0] s_wstrb;
    logic                    s_wvalid;
    logic                    s_wready;
    logic [1:0]              s_bresp;
    logic                    s_bvalid;
    logic                    s_bready;
    logic [ADDR_WIDTH-1:0]   s_araddr;
    logic                    s_arvalid;
    logic                    s_arready;
    logic [DATA_WIDTH-1:0]   s_rdata;
    logic [1:0]              s_rresp;
    logic                    s_rvalid;
    logic                    s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axil_uart_regs.sv
// AXI4-Lite register front-end for the UART: TX push, RX pop, FIFO status,
// sticky error flags and a level interrupt.
module axil_uart_regs #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    axil_uart_regs_if.slave        s_axil,
    input  logic [7:0]             RX_data,
    input  logic                   Empty,
    output logic                   rd_uart_en,
    output logic [7:0]             TX_data,
    output logic                   wr_uart_en,
    input  logic                   Full,
    output logic                   irq
);

    localparam logic [1:0] REG_RX     = 2'd0;
    localparam logic [1:0] REG_TX     = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_WAIT_AW, WR_WAIT_W, WR_RESP} wr_state_e;

    rd_state_e             rd_state_q, rd_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    wr_state_e             wr_state_q, wr_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ADDR_WIDTH-3:0] awaddr_q, awaddr_d;
    logic [9:0]            wdata_q, wdata_d;
    logic [1:0]            wstrb_q, wstrb_d;

    logic [1:0]            ctrl_q, ctrl_d;
    logic                  rx_unf_q, rx_unf_d;
    logic                  tx_ovf_q, tx_ovf_d;
    logic                  irq_q, irq_d;

    // Read channel decode, evaluated in the AR accept cycle
    logic                  ar_hs, ar_err, rd_pop, rx_unf_set;
    logic [1:0]            ar_reg;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ar_hs      = s_axil.s_arvalid & arready_q;
    assign ar_err     = |s_axil.s_araddr[ADDR_WIDTH-1:4];
    assign ar_reg     = s_axil.s_araddr[3:2];
    assign rd_pop     = ar_hs & ~ar_err & (ar_reg == REG_RX) & ~Empty;
    assign rx_unf_set = ar_hs & ~ar_err & (ar_reg == REG_RX) & Empty;

    always_comb begin
        rd_word = '0;
        if (!ar_err) begin
            case (ar_reg)
                REG_RX: begin
                    if (!Empty) begin
                        rd_word[DATA_WIDTH-1] = 1'b1;
                        rd_word[7:0]          = RX_data;
                    end
                end
                REG_STATUS: rd_word[3:0] = {tx_ovf_q, rx_unf_q, Full, Empty};
                REG_CTRL:   rd_word[1:0] = ctrl_q;
                default:    rd_word = '0;
            endcase
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_RESP;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_word;
                    rresp_d    = ar_err ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    arready_d  = 1'b1;
                end
            end
            RD_RESP: begin
                if (s_axil.s_rready) begin
                    rd_state_d = RD_IDLE;
                    arready_d  = 1'b1;
                    rvalid_d   = 1'b0;
                    rdata_d    = '0;
                    rresp_d    = RESP_OKAY;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // Whichever channel arrived first is taken from its holding register
    logic                  aw_hs, w_hs, aw_have, w_have, wr_exec, wr_err;
    logic [ADDR_WIDTH-3:0] wa;
    logic [9:0]            wd;
    logic [1:0]            ws, wr_reg;
    logic                  tx_sel, wr_push, tx_ovf_set, ctrl_sel, rx_unf_clr, tx_ovf_clr;

    assign aw_hs      = s_axil.s_awvalid & awready_q;
    assign w_hs       = s_axil.s_wvalid & wready_q;
    assign aw_have    = (wr_state_q == WR_WAIT_W);
    assign w_have     = (wr_state_q == WR_WAIT_AW);
    assign wr_exec    = (aw_hs | aw_have) & (w_hs | w_have);
    assign wa         = aw_have ? awaddr_q : s_axil.s_awaddr[ADDR_WIDTH-1:2];
    assign wd         = w_have ? wdata_q : s_axil.s_wdata[9:0];
    assign ws         = w_have ? wstrb_q : s_axil.s_wstrb[1:0];
    assign wr_err     = |wa[ADDR_WIDTH-3:2];
    assign wr_reg     = wa[1:0];
    assign tx_sel     = wr_exec & ~wr_err & (wr_reg == REG_TX) & ws[0];
    assign wr_push    = tx_sel & ~Full;
    assign tx_ovf_set = tx_sel & Full;
    assign ctrl_sel   = wr_exec & ~wr_err & (wr_reg == REG_CTRL);
    assign rx_unf_clr = ctrl_sel & ws[1] & wd[8];
    assign tx_ovf_clr = ctrl_sel & ws[1] & wd[9];

    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (wr_exec) begin
                    wr_state_d = WR_RESP;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_err ? RESP_SLVERR : RESP_OKAY;
                end else if (aw_hs) begin
                    wr_state_d = WR_WAIT_W;
                    awready_d  = 1'b0;
                    wready_d   = 1'b1;
                    awaddr_d   = s_axil.s_awaddr[ADDR_WIDTH-1:2];
                end else if (w_hs) begin
                    wr_state_d = WR_WAIT_AW;
                    awready_d  = 1'b1;
                    wready_d   = 1'b0;
                    wdata_d    = s_axil.s_wdata[9:0];
                    wstrb_d    = s_axil.s_wstrb[1:0];
                end else begin
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end
            end
            WR_WAIT_AW, WR_WAIT_W: begin
                if (wr_exec) begin
                    wr_state_d = WR_RESP;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
            WR_RESP: begin
                if (s_axil.s_bready) begin
                    wr_state_d = WR_IDLE;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    bvalid_d   = 1'b0;
                    bresp_d    = RESP_OKAY;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    // A fresh set outranks a W1C landing in the same cycle
    always_comb begin
        ctrl_d   = ((ctrl_sel & ws[0]) == 1'b1) ? wd[1:0] : ctrl_q;
        rx_unf_d = (rx_unf_q & ~rx_unf_clr) | rx_unf_set;
        tx_ovf_d = (tx_ovf_q & ~tx_ovf_clr) | tx_ovf_set;
        irq_d    = (ctrl_q[0] & ~Empty) | (ctrl_q[1] & ~Full) | rx_unf_q | tx_ovf_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ctrl_q   <= '0;
            rx_unf_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            rx_unf_q <= rx_unf_d;
            tx_ovf_q <= tx_ovf_d;
            irq_q    <= irq_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s_axil.s_wdata[DATA_WIDTH-1:10], s_axil.s_wstrb[DATA_WIDTH/8-1:2],
                           s_axil.s_awaddr[1:0], s_axil.s_araddr[1:0]};

    assign s_axil.s_arready = arready_q;
    assign s_axil.s_rvalid  = rvalid_q;
    assign s_axil.s_rdata   = rdata_q;
    assign s_axil.s_rresp   = rresp_q;
    assign s_axil.s_awready = awready_q;
    assign s_axil.s_wready  = wready_q;
    assign s_axil.s_bvalid  = bvalid_q;
    assign s_axil.s_bresp   = bresp_q;

    assign rd_uart_en = rd_pop;
    assign wr_uart_en = wr_push;
    assign TX_data    = wr_push ? wd[7:0] : '0;
    assign irq        = irq_q;

endmodule

// File: tb/tb_axil_uart_regs.sv
// Directed bench for axil_uart_regs: expected read data, write responses and
// TX bytes are queued as stimulus is issued and checked as the DUT responds.
module tb_axil_uart_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] RX_data;
    logic       Empty;
    logic       Full;
    logic       rd_uart_en;
    logic [7:0] TX_data;
    logic       wr_uart_en;
    logic       irq;

    int total = 0;
    int bad   = 0;
    int tx_pushes = 0;
    int rx_pops   = 0;

    logic [33:0] exp_rd[$];
    logic [1:0]  exp_b[$];
    logic [7:0]  exp_tx[$];

    axil_uart_regs_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    axil_uart_regs #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .Clk        (clk),
        .Reset      (rst),
        .s_axil     (bus),
        .RX_data    (RX_data),
        .Empty      (Empty),
        .rd_uart_en (rd_uart_en),
        .TX_data    (TX_data),
        .wr_uart_en (wr_uart_en),
        .Full       (Full),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every TX push must match the oldest queued byte
    always @(negedge clk) begin
        if (wr_uart_en === 1'b1) begin
            tx_pushes++;
            total++;
            assert (exp_tx.size() != 0) else begin
                bad++;
                $error("FAIL tx_unexpected_push: observed=%h expected=none", TX_data);
            end
            if (exp_tx.size() != 0) check("tx_data", 34'(TX_data), 34'(exp_tx.pop_front()));
        end
        if (rd_uart_en === 1'b1) rx_pops++;
    end

    task automatic rd(input logic [5:0] addr, input logic [31:0] edata, input logic [1:0] eresp,
                      input int epop);
        int pops0;
        bit ok;
        pops0 = rx_pops;
        exp_rd.push_back({eresp, edata});
        bus.s_araddr  = addr;
        bus.s_arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.s_arready;
            step();
        end
        bus.s_arvalid = 1'b0;
        check("rd_ar_accept", 34'(ok), 34'(1));
        bus.s_rready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.s_rvalid) begin
                ok = 1'b1;
                check("rd_data_resp", {bus.s_rresp, bus.s_rdata}, exp_rd.pop_front());
            end
            step();
        end
        bus.s_rready = 1'b0;
        check("rd_r_timeout", 34'(ok), 34'(1));
        @(negedge clk);
        check("rd_rvalid_drop", 34'(bus.s_rvalid), 34'(0));
        check("rd_pop_count", 34'(rx_pops - pops0), 34'(epop));
        step();
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int w_dly, input int aw_dly, input int b_dly,
                      input logic [1:0] eresp, input int epush);
        int  pushes0;
        int  c;
        bit  aw_done, w_done, aw_acc, w_acc, ok;
        pushes0 = tx_pushes;
        aw_done = 1'b0;
        w_done  = 1'b0;
        c = 0;
        exp_b.push_back(eresp);
        if (epush != 0) exp_tx.push_back(data[7:0]);
        while (!(aw_done && w_done) && c < 30) begin
            if (!aw_done && c >= aw_dly) begin
                bus.s_awaddr  = addr;
                bus.s_awvalid = 1'b1;
            end
            if (!w_done && c >= w_dly) begin
                bus.s_wdata  = data;
                bus.s_wstrb  = strb;
                bus.s_wvalid = 1'b1;
            end
            @(negedge clk);
            if (w_done && !aw_done) check("wr_wready_held_low", 34'(bus.s_wready), 34'(0));
            aw_acc = bus.s_awvalid && bus.s_awready;
            w_acc  = bus.s_wvalid && bus.s_wready;
            step();
            if (aw_acc) begin aw_done = 1'b1; bus.s_awvalid = 1'b0; end
            if (w_acc)  begin w_done  = 1'b1; bus.s_wvalid  = 1'b0; end
            c++;
        end
        check("wr_accept", 34'(aw_done && w_done), 34'(1));
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            check("wr_bvalid_held", 34'(bus.s_bvalid), 34'(1));
            step();
        end
        bus.s_bready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.s_bvalid) begin
                ok = 1'b1;
                check("wr_bresp", 34'(bus.s_bresp), 34'(exp_b.pop_front()));
            end
            step();
        end
        bus.s_bready = 1'b0;
        check("wr_b_timeout", 34'(ok), 34'(1));
        @(negedge clk);
        check("wr_bvalid_drop", 34'(bus.s_bvalid), 34'(0));
        check("wr_push_count", 34'(tx_pushes - pushes0), 34'(epush));
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_arready"}, 34'(bus.s_arready), 34'(0));
        check({tag, "_rvalid"},  34'(bus.s_rvalid),  34'(0));
        check({tag, "_rdata"},   {bus.s_rresp, bus.s_rdata}, 34'(0));
        check({tag, "_awready"}, 34'(bus.s_awready), 34'(0));
        check({tag, "_wready"},  34'(bus.s_wready),  34'(0));
        check({tag, "_bvalid"},  34'({bus.s_bvalid, bus.s_bresp}), 34'(0));
        check({tag, "_irq"},     34'(irq), 34'(0));
        check({tag, "_uart_en"}, 34'({rd_uart_en, wr_uart_en}), 34'(0));
        check({tag, "_tx_data"}, 34'(TX_data), 34'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; Empty = 1'b1; Full = 1'b0; RX_data = 8'h00;
        bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
        bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step(); step();
        check("idle_readys", 34'({bus.s_arready, bus.s_awready, bus.s_wready}), 34'(3'b111));

        // TX push, same-cycle AW/W, then W three cycles ahead of AW
        wr(6'h04, 32'h0000_0041, 4'hF, 0, 0, 2, 2'b00, 1);
        wr(6'h04, 32'h0000_0042, 4'hF, 0, 3, 5, 2'b00, 1);
        check("irq_quiet", 34'(irq), 34'(0));

        // RX pop, then underflow
        Empty = 1'b0; RX_data = 8'h5A;
        rd(6'h00, 32'h8000_005A, 2'b00, 1);
        Empty = 1'b1;
        rd(6'h00, 32'h0, 2'b00, 0);
        rd(6'h08, 32'h5, 2'b00, 0);
        check("irq_underflow", 34'(irq), 34'(1));
        wr(6'h0C, 32'h0000_0103, 4'h2, 0, 0, 0, 2'b00, 0);
        rd(6'h08, 32'h1, 2'b00, 0);
        rd(6'h0C, 32'h0, 2'b00, 0);

        // TX overflow and its W1C
        Full = 1'b1;
        wr(6'h04, 32'h0000_0077, 4'hF, 0, 0, 0, 2'b00, 0);
        rd(6'h08, 32'hB, 2'b00, 0);
        check("irq_overflow", 34'(irq), 34'(1));
        wr(6'h0C, 32'h0000_0200, 4'hF, 0, 0, 0, 2'b00, 0);
        rd(6'h08, 32'h3, 2'b00, 0);
        check("irq_cleared", 34'(irq), 34'(0));
        wr(6'h04, 32'h0000_0099, 4'hE, 0, 0, 0, 2'b00, 0);
        rd(6'h08, 32'h3, 2'b00, 0);
        Full = 1'b0;

        // Underflow set and W1C of the same flag in one cycle: set wins
        bus.s_araddr = 6'h00; bus.s_arvalid = 1'b1;
        bus.s_awaddr = 6'h0C; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'h0000_0100; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        @(negedge clk);
        check("conc_readys", 34'({bus.s_arready, bus.s_awready, bus.s_wready}), 34'(3'b111));
        step();
        bus.s_arvalid = 1'b0; bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check("conc_rvalid", 34'(bus.s_rvalid), 34'(1));
        check("conc_rdata", {bus.s_rresp, bus.s_rdata}, 34'(0));
        check("conc_bvalid", 34'({bus.s_bvalid, bus.s_bresp}), 34'(3'b100));
        bus.s_rready = 1'b1; bus.s_bready = 1'b1;
        step();
        bus.s_rready = 1'b0; bus.s_bready = 1'b0;
        rd(6'h08, 32'h5, 2'b00, 0);
        wr(6'h0C, 32'h0000_0100, 4'hF, 0, 0, 0, 2'b00, 0);
        rd(6'h08, 32'h1, 2'b00, 0);

        // Ignored and erroring addresses
        wr(6'h00, 32'h0000_00FF, 4'hF, 0, 0, 0, 2'b00, 0);
        wr(6'h14, 32'h0000_0041, 4'hF, 0, 0, 0, 2'b10, 0);
        wr(6'h1C, 32'h0000_0303, 4'hF, 0, 0, 0, 2'b10, 0);
        rd(6'h0C, 32'h0, 2'b00, 0);

        // rx interrupt enable: irq follows Empty with one cycle of lag
        Full = 1'b1;
        wr(6'h0C, 32'h0000_0001, 4'hF, 0, 0, 0, 2'b00, 0);
        step(); step();
        check("irq_pre_rx", 34'(irq), 34'(0));
        Empty = 1'b0; RX_data = 8'h33;
        @(negedge clk);
        check("irq_same_cycle", 34'(irq), 34'(0));
        step();
        check("irq_next_cycle", 34'(irq), 34'(1));
        rd(6'h10, 32'h0, 2'b10, 0);
        rd(6'h0C, 32'h1, 2'b00, 0);
        rd(6'h04, 32'h0, 2'b00, 0);

        // Reset with a read response pending and a write half captured
        Full = 1'b0;
        bus.s_araddr = 6'h0C; bus.s_arvalid = 1'b1;
        step();
        bus.s_arvalid = 1'b0;
        bus.s_wdata = 32'h0000_0055; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        step();
        bus.s_wvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_rvalid", 34'(bus.s_rvalid), 34'(1));
        check("pre_rst_ready", 34'({bus.s_awready, bus.s_wready}), 34'(2'b10));
        check("pre_rst_irq", 34'(irq), 34'(1));
        step();
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        step();
        rst = 1'b0;
        step(); step();
        wr(6'h04, 32'h0000_0055, 4'hF, 0, 0, 0, 2'b00, 1);
        rd(6'h0C, 32'h0, 2'b00, 0);
        rd(6'h00, 32'h8000_0033, 2'b00, 1);
        check("post_rst_irq", 34'(irq), 34'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
